// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master modport; the datapath side takes slave.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic [3:0] state;
  logic       illegalOp;

  modport master (
    input  opcode,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           state, illegalOp
  );

  modport slave (
    output opcode,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           state, illegalOp
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for a multicycle MIPS-style datapath (lw/sw/R-type/beq/j).
// Define MC_ADDI_EN to add the ADDIEX/ADDIWB states for addi; otherwise addi is unsupported.
module mc_control_fsm (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master bus
);

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] JEX     = 4'd9;
`ifdef MC_ADDI_EN
  localparam logic [3:0] ADDIEX  = 4'd10;
  localparam logic [3:0] ADDIWB  = 4'd11;
`endif

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
`ifdef MC_ADDI_EN
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
`endif

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               illegal_q;
  logic               illegal_d;

  // Output values for the state being entered; registered alongside state_q
  logic       pc_write_d;
  logic       pc_write_cond_d;
  logic       ior_d_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       ir_write_d;
  logic       reg_dst_d;
  logic       mem_to_reg_d;
  logic       reg_write_d;
  logic       alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;
  logic [1:0] pc_source_d;

  // Next-state, sticky illegal flag, and Moore decode of the next state
  always_comb begin
    state_d         = FETCH;
    illegal_d       = illegal_q;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    ior_d_d         = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    ir_write_d      = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 2'b00;
    pc_source_d     = 2'b00;

    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
`ifdef MC_ADDI_EN
      ADDIEX:  state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase

    // Synchronous reset overrides whatever transition was chosen
    if (reset) begin
      state_d   = FETCH;
      illegal_d = 1'b0;
    end

    case (state_d)
      FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        pc_write_d  = 1'b1;
      end
      DECODE: alu_src_b_d = 2'b11;
      MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      MEMRD: begin
        mem_read_d = 1'b1;
        ior_d_d    = 1'b1;
      end
      MEMWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      MEMWR: begin
        mem_write_d = 1'b1;
        ior_d_d     = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      RTYPEWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      BEQEX: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      JEX: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ADDIWB: reg_write_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, flag and control output registers
  always_ff @(posedge clk) begin
    state_q         <= state_d;
    illegal_q       <= illegal_d;
    bus.pcWrite     <= pc_write_d;
    bus.pcWriteCond <= pc_write_cond_d;
    bus.iorD        <= ior_d_d;
    bus.memRead     <= mem_read_d;
    bus.memWrite    <= mem_write_d;
    bus.irWrite     <= ir_write_d;
    bus.regDst      <= reg_dst_d;
    bus.memToReg    <= mem_to_reg_d;
    bus.regWrite    <= reg_write_d;
    bus.aluSrcA     <= alu_src_a_d;
    bus.aluSrcB     <= alu_src_b_d;
    bus.aluOp       <= alu_op_d;
    bus.pcSource    <= pc_source_d;
  end

  assign bus.state     = state_q;
  assign bus.illegalOp = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: an instruction-level model predicts the
// per-cycle state/controls; a separate monitor compares each cycle.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  // {illegalOp, state[3:0], pcWrite, pcWriteCond, iorD, memRead, memWrite,
  //  irWrite, regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource}
  logic [20:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  bit stim_done = 1'b0;

  localparam int N_CYCLES = 3000;

  // Expected control word for a state, straight from the state table
  function automatic logic [15:0] ctrl_of(input int st);
    logic pw, pwc, iord, mr, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    pw = 0; pwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; rdst = 0; m2r = 0;
    rw = 0; asa = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc};
  endfunction

  function automatic bit supported(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MC_ADDI_EN
      6'b001000: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Stimulus and reference model
  initial begin
    int cur;
    int nxt;
    bit ill;
    bit rst;
    int rst_left;
    int n_instr;
    bit did_mid_reset;
    logic [5:0] op_cur;
    logic [5:0] script[$];
    int plan[$];

    script = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
               6'b111111, 6'b100011, 6'b001000, 6'b100011};
    cur = 0; ill = 1'b0; rst_left = 2; n_instr = 0; did_mid_reset = 1'b0;
    op_cur = 6'b000000;
    bus.opcode = 6'b000000;

    repeat (N_CYCLES) begin
      @(negedge clk);
      cycle++;
      rst = 1'b0;
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if (cur == 3 && n_instr >= 9 && !did_mid_reset) begin
        rst = 1'b1;
        did_mid_reset = 1'b1;
      end else if (n_instr > 9 && $urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        rst_left = int'($urandom_range(0, 2));
      end
      reset = rst;

      if (!rst && cur == 0) begin
        if (script.size() > 0) op_cur = script.pop_front();
        else begin
          case ($urandom_range(0, 6))
            0: op_cur = 6'b100011;
            1: op_cur = 6'b101011;
            2: op_cur = 6'b000000;
            3: op_cur = 6'b000100;
            4: op_cur = 6'b000010;
            5: op_cur = 6'b001000;
            default: op_cur = 6'($urandom);
          endcase
        end
        n_instr++;
        case (op_cur)
          6'b100011: plan = '{1, 2, 3, 4};
          6'b101011: plan = '{1, 2, 5};
          6'b000000: plan = '{1, 6, 7};
          6'b000100: plan = '{1, 8};
          6'b000010: plan = '{1, 9};
`ifdef MC_ADDI_EN
          6'b001000: plan = '{1, 10, 11};
`endif
          default:   plan = '{1};
        endcase
      end

      // Opcode only matters in DECODE and MEMADR; scramble it elsewhere
      if (cur == 1 || cur == 2) bus.opcode = op_cur;
      else bus.opcode = 6'($urandom);

      if (rst) begin
        nxt = 0;
        ill = 1'b0;
        plan.delete();
      end else begin
        if (cur == 1 && !supported(op_cur)) ill = 1'b1;
        nxt = (plan.size() > 0) ? plan.pop_front() : 0;
      end
      exp_q.push_back({ill, 4'(nxt), ctrl_of(nxt)});
      cur = nxt;
    end
    stim_done = 1'b1;
  end

  // Monitor: compare one expected entry per clock, away from the edge
  initial begin
    logic [20:0] act;
    logic [20:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus.illegalOp, bus.state, bus.pcWrite, bus.pcWriteCond, bus.iorD,
               bus.memRead, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
               bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.pcSource};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t {ill,state,ctrl}: got %h expected %h", $time, act, e);
        end
        vectors++;
        if (bus.memRead === 1'b1 && bus.memWrite === 1'b1) begin
          miscompares++;
          $display("FAIL mem_strobe_excl t=%0t state=%0d: got both memRead and memWrite, required at most one",
                   $time, bus.state);
        end
      end
    end
  end

  // End of run: every prediction must have been consumed
  initial begin
    wait (stim_done);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit in case the clock or processes stall
  initial begin
    #((N_CYCLES + 100) * 10 * 2);
    $display("FAIL timeout: got no end of run, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 opcode  input  6  instr[31:26] from instruction register; valid from DECODE onward.
REQ-005 pcWrite  output  1  unconditional PC load enable.
REQ-006 pcWriteCond  output  1  PC load enable qualified by ALU zero in datapath.
REQ-007 iorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 memRead, memWrite  output  1 each  memory strobes.
REQ-009 irWrite  output  1  instruction register load enable.
REQ-010 regDst  output  1  write-register select: 0=rt, 1=rd.
REQ-011 memToReg  output  1  write-data select: 0=ALUOut, 1=MDR.
REQ-012 regWrite  output  1  register file write enable.
REQ-013 aluSrcA  output  1; aluSrcB  output  2; aluOp  output  2; pcSource  output  2  datapath mux/ALU controls.
REQ-014 state  output  4  current state encoding, for debug.
REQ-015 illegalOp  output  1  sticky unsupported-opcode flag.

Function
REQ-016 Moore FSM: all control outputs decoded from current state only; outputs not listed for a state SHALL be 0.
REQ-017 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9, ADDIEX=10, ADDIWB=11; 12-15 unreachable, treated as FETCH next.
REQ-018 FETCH: memRead=1, iorD=0, irWrite=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, pcWrite=1; next DECODE.
REQ-019 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00; next by opcode: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000010->JEX, 001000->ADDIEX, other->FETCH.
REQ-020 MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00; next MEMRD if opcode=100011, else MEMWR.
REQ-021 MEMRD: memRead=1, iorD=1 -> MEMWB. MEMWB: regDst=0, memToReg=1, regWrite=1 -> FETCH.
REQ-022 MEMWR: memWrite=1, iorD=1 -> FETCH.
REQ-023 RTYPEEX: aluSrcA=1, aluSrcB=00, aluOp=10 -> RTYPEWB. RTYPEWB: regDst=1, memToReg=0, regWrite=1 -> FETCH.
REQ-024 BEQEX: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 -> FETCH.
REQ-025 JEX: pcWrite=1, pcSource=10 -> FETCH.
REQ-026 ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB. ADDIWB: regDst=0, memToReg=0, regWrite=1 -> FETCH.
REQ-027 Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported opcode 2 (no register/memory write).
REQ-028 illegalOp set on the clk edge leaving DECODE with unsupported opcode; held until reset; FSM continues fetching.
REQ-029 opcode changes outside DECODE/MEMADR SHALL not affect sequencing; at most one of memRead/memWrite asserted in any state.

Reset
REQ-030 reset=1 at a rising edge forces state=FETCH and illegalOp=0, overriding any transition, including mid-instruction.
REQ-031 While reset held, outputs are FETCH decode; first fetch proceeds on the first edge after reset deasserts.

Configuration
REQ-032 Macro MC_ADDI_EN: defined -> ADDIEX/ADDIWB present, opcode 001000 executes as in REQ-026.
REQ-033 MC_ADDI_EN undefined -> states 10/11 absent (treated as unreachable), opcode 001000 handled as unsupported (DECODE->FETCH, illegalOp set).

Verification
REQ-034 reset high 2 cycles, release, opcode=100011 -> state 0,1,2,3,4,0; regWrite=1 & memToReg=1 only in state 4.
REQ-035 opcode=101011 -> 0,1,2,5,0; memWrite=1 & iorD=1 in state 5 only; regWrite never 1.
REQ-036 opcode=000000 then 000100 then 000010 -> 0,1,6,7 | 0,1,8 (pcWriteCond=1, pcSource=01) | 0,1,9 (pcWrite=1, pcSource=10).
REQ-037 opcode=111111 -> 0,1,0, illegalOp rises after DECODE, stays 1 through next lw; cleared only by reset.
REQ-038 reset asserted while state=3 -> state=0 next edge, illegalOp=0, no memWrite/regWrite pulse.
REQ-039 opcode=001000 with MC_ADDI_EN -> 0,1,10,11,0 regDst=0 regWrite=1; without -> 0,1,0, illegalOp=1.
